// File: rtl/clock_key_ctrl_pkg.sv
// Shared encodings for the front-panel key controller.
// Mode one-hots, add_key bit positions and target selects.
package clock_key_ctrl_pkg;

    localparam logic [2:0] MODE_RUN  = 3'b000;
    localparam logic [2:0] MODE_HOUR = 3'b100;
    localparam logic [2:0] MODE_MIN  = 3'b010;
    localparam logic [2:0] MODE_SEC  = 3'b001;

    localparam int ADD_INC = 0;
    localparam int ADD_DEC = 1;
    localparam int ADD_REP = 2;

    localparam logic [1:0] TCK_TIME  = 2'b01;
    localparam logic [1:0] TCK_ALARM = 2'b10;

    function automatic logic [2:0] next_mode(
        input logic [2:0] m
    );
        logic [2:0] n;
        n = MODE_RUN;
        unique case (1'b1)
            (m == MODE_RUN):  n = MODE_HOUR;
            (m == MODE_HOUR): n = MODE_MIN;
            (m == MODE_MIN):  n = MODE_SEC;
            default:          n = MODE_RUN;
        endcase
        return n;
    endfunction

    function automatic logic [15:0] sat_inc(
        input logic [15:0] v
    );
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/clock_key_ctrl_debounce.sv
// Two-flop synchronizer plus tick-based debouncer for one key.
// Emits a one-clk press pulse on each accepted rising edge.
module key_debounce
    import clock_key_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_1ms,
    input  logic key_raw,
    output logic level,
    output logic press
);

    logic        s1;
    logic        s2;
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= key_raw;
            s2    <= s1;
            press <= 1'b0;
            // any bounce back to the current level restarts the count
            if (s2 == level) begin
                cnt <= '0;
            end else if (tick_1ms) begin
                if (cnt >= 16'(DEBOUNCE_MS - 1)) begin
                    level <= s2;
                    press <= s2;
                    cnt   <= '0;
                end else begin
                    cnt <= sat_inc(cnt);
                end
            end
        end
    end

endmodule

// File: rtl/clock_key_ctrl.sv
// Front-panel key controller: debounce, set-mode FSM,
// idle timeout, time/alarm select and up-key auto-repeat.
module clock_key_ctrl
    import clock_key_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 1000,
    parameter int REPEAT_MS     = 200,
    parameter int TIMEOUT_MS    = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1ms,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_sel,
    output logic [1:0] time_clock_key,
    output logic [2:0] mode_key,
    output logic [2:0] add_key
);

    logic [3:0]  raw;
    logic [3:0]  lvl;
    logic [3:0]  prs;
    logic        mode_p;
    logic        up_p;
    logic        down_p;
    logic        sel_p;
    logic        up_lvl;
    logic        any_press;
    logic [15:0] idle_cnt;
    logic [15:0] rep_cnt;
    logic [15:0] rep_target;
    logic        rep_active;
    logic        rep_phase;
    logic        rep_fire;
    logic        set_mode;
    logic [2:0]  add_next;
    wire         lvl_unused = ^{lvl[3:2], lvl[0]};

    assign raw = {key_sel, key_down, key_up, key_mode};

    for (genvar g = 0; g < 4; g++) begin : g_deb
        key_debounce #(
            .DEBOUNCE_MS(DEBOUNCE_MS)
        ) u_deb (
            .clk     (clk),
            .reset   (reset),
            .tick_1ms(tick_1ms),
            .key_raw (raw[g]),
            .level   (lvl[g]),
            .press   (prs[g])
        );
    end

    assign mode_p    = prs[0];
    assign up_p      = prs[1];
    assign down_p    = prs[2];
    assign sel_p     = prs[3];
    assign up_lvl    = lvl[1];
    assign any_press = |prs;
    assign set_mode  = (mode_key != MODE_RUN);

    always_comb begin
        rep_target = rep_phase ? 16'(REPEAT_MS - 1)
                               : 16'(LONG_PRESS_MS - 1);
        rep_fire   = rep_active && up_lvl && tick_1ms &&
                     !up_p && !down_p &&
                     (rep_cnt >= rep_target);
        add_next   = '0;
        // mode press wins; simultaneous up+down cancels
        if (set_mode && !mode_p) begin
            if (up_p && !down_p)
                add_next[ADD_INC] = 1'b1;
            else if (down_p && !up_p)
                add_next[ADD_DEC] = 1'b1;
            else if (rep_fire)
                add_next[ADD_REP] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            time_clock_key <= TCK_TIME;
            mode_key       <= MODE_RUN;
            add_key        <= '0;
            idle_cnt       <= '0;
            rep_cnt        <= '0;
            rep_active     <= 1'b0;
            rep_phase      <= 1'b0;
        end else begin
            add_key <= add_next;

            if (mode_p)
                mode_key <= next_mode(mode_key);
            else if (set_mode && tick_1ms &&
                     idle_cnt >= 16'(TIMEOUT_MS - 1))
                mode_key <= MODE_RUN;

            if (sel_p && !set_mode)
                time_clock_key <= ~time_clock_key;

            if (!set_mode || any_press)
                idle_cnt <= '0;
            else if (tick_1ms)
                idle_cnt <= sat_inc(idle_cnt);

            // long-press wait first, then fixed repeat period
            if (down_p || !up_lvl) begin
                rep_active <= 1'b0;
                rep_phase  <= 1'b0;
                rep_cnt    <= '0;
            end else if (up_p) begin
                rep_active <= 1'b1;
                rep_phase  <= 1'b0;
                rep_cnt    <= '0;
            end else if (rep_active && tick_1ms) begin
                if (rep_cnt >= rep_target) begin
                    rep_cnt   <= '0;
                    rep_phase <= 1'b1;
                end else begin
                    rep_cnt <= sat_inc(rep_cnt);
                end
            end
        end
    end

endmodule
